// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int calc_cpb(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_half(input int clk_freq, input int baud);
    return calc_cpb(clk_freq, baud) / 2;
  endfunction

  // Bits needed to hold CPB-1.
  function automatic int cnt_width(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit, rejects false starts
// and flags framing errors, holding off in BREAK while the line stays low.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int D_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_done,
  output logic               frame_err,
  output logic               busy
);

  localparam int CPB  = calc_cpb(CLK_FREQ, BAUD);
  localparam int HALF = calc_half(CLK_FREQ, BAUD);
  localparam int CW   = cnt_width(CPB);
  localparam int BW   = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_WIDTH - 1);

  rx_state_t state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [BW-1:0]      bit_idx, bit_idx_n;
  logic [D_WIDTH-1:0] shreg, shreg_n;
  logic [D_WIDTH-1:0] data_n;
  logic               done_n, err_n;
  logic               rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = rx_data;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      // Re-check the start bit at its midpoint; a high line here was a glitch.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt == CPB_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[D_WIDTH-1:1]};
          if (bit_idx == BIT_LAST) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + BW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      // Leaving at mid stop bit lets an immediately following start edge be seen.
      STOP: begin
        if (cnt == CPB_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scenario bench for uart_rx_frame at CPB=16: a scoreboard queue of expected
// bytes is filled as frames are sent and drained by the rx_done monitor.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam realtime BIT_T  = 160.0;
  localparam realtime FAST_T = 156.0;
  localparam realtime SLOW_T = 164.0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         done_cyc[$];
  logic [7:0] exp_byte;
  logic [7:0] last_good = 8'h00;
  int         done_count = 0;
  int         err_count = 0;
  int         cyc = 0;
  logic       done_prev = 1'b0;
  logic       busy_after_done = 1'bx;
  int         busy_run = 0;
  int         max_busy_run = 0;

  uart_rx_frame #(
    .CLK_FREQ (16_000_000),
    .BAUD     (1_000_000),
    .D_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every rx_done.
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
      busy_run  = 0;
    end else begin
      if (done_prev) busy_after_done = busy;
      done_prev = rx_done;
      busy_run = busy ? busy_run + 1 : 0;
      if (busy_run > max_busy_run) max_busy_run = busy_run;
      if (rx_done || frame_err) begin
        checks++;
        if (rx_done && frame_err) begin
          errors++;
          $display("[TB] FAIL done_err_overlap: rx_done=%b frame_err=%b, required not both high", rx_done, frame_err);
        end
      end
      if (rx_done) begin
        done_count++;
        done_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_rx_done: got %h, no frame expected", rx_data);
        end else begin
          exp_byte = exp_q.pop_front();
          if (rx_data !== exp_byte) begin
            errors++;
            $display("[TB] FAIL rx_data: got %h, expected %h", rx_data, exp_byte);
          end
          last_good = exp_byte;
        end
      end
      if (frame_err) begin
        err_count++;
        checks++;
        if (rx_data !== last_good) begin
          errors++;
          $display("[TB] FAIL rx_data_hold_on_err: got %h, expected %h", rx_data, last_good);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input realtime bt);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bt);
    end
    rx = stop_bit;
    #(bt);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_rx_data", 32'(rx_data), 32'h00);
    check_val("reset_rx_done", 32'(rx_done), 32'h0);
    check_val("reset_frame_err", 32'(frame_err), 32'h0);
    check_val("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("post_reset_busy", 32'(busy), 32'h0);
  endtask

  task automatic test_single();
    int d0, e0;
    idle(10);
    d0 = done_count;
    e0 = err_count;
    busy_after_done = 1'bx;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, BIT_T);
    idle(4);
    check_val("single_done_count", 32'(done_count - d0), 32'd1);
    check_val("single_rx_data", 32'(rx_data), 32'hA5);
    check_val("single_no_frame_err", 32'(err_count - e0), 32'd0);
    check_val("single_busy_after_done", 32'(busy_after_done), 32'h0);
  endtask

  task automatic test_back_to_back();
    int d0;
    idle(10);
    d0 = done_count;
    done_cyc.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_byte(8'h00, 1'b1, BIT_T);
    send_byte(8'hFF, 1'b1, BIT_T);
    send_byte(8'h3C, 1'b1, BIT_T);
    idle(4);
    check_val("b2b_done_count", 32'(done_count - d0), 32'd3);
    check_val("b2b_rx_data", 32'(rx_data), 32'h3C);
    if (done_cyc.size() >= 3) begin
      check_val("b2b_spacing_1", 32'(done_cyc[1] - done_cyc[0]), 32'd160);
      check_val("b2b_spacing_2", 32'(done_cyc[2] - done_cyc[1]), 32'd160);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL b2b_pulses: got %0d pulses, expected 3", done_cyc.size());
    end
  endtask

  task automatic test_glitch();
    int d0, e0;
    idle(10);
    d0 = done_count;
    e0 = err_count;
    max_busy_run = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check_val("glitch_no_done", 32'(done_count - d0), 32'd0);
    check_val("glitch_no_err", 32'(err_count - e0), 32'd0);
    check_val("glitch_busy_le9", 32'(max_busy_run <= 9), 32'd1);
    check_val("glitch_busy_seen", 32'(max_busy_run > 0), 32'd1);
    check_val("glitch_idle", 32'(busy), 32'h0);
  endtask

  task automatic test_framing_error();
    int d0, e0;
    logic [7:0] prior;
    idle(10);
    prior = last_good;
    d0 = done_count;
    e0 = err_count;
    send_byte(8'h55, 1'b0, BIT_T);
    repeat (50) @(negedge clk);
    check_val("ferr_count", 32'(err_count - e0), 32'd1);
    check_val("ferr_no_done", 32'(done_count - d0), 32'd0);
    check_val("ferr_rx_data_held", 32'(rx_data), 32'(prior));
    check_val("ferr_busy_in_break", 32'(busy), 32'h1);
    idle(20);
    check_val("ferr_idle_after_break", 32'(busy), 32'h0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, BIT_T);
    idle(4);
    check_val("ferr_recover_done", 32'(done_count - d0), 32'd1);
    check_val("ferr_recover_data", 32'(rx_data), 32'h81);
    check_val("ferr_total_errs", 32'(err_count - e0), 32'd1);
  endtask

  task automatic test_reset_midframe();
    int d0, e0;
    idle(10);
    d0 = done_count;
    e0 = err_count;
    fork
      send_byte(8'hC3, 1'b1, BIT_T);
      begin
        repeat (115) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check_val("midrst_rx_data", 32'(rx_data), 32'h00);
        check_val("midrst_rx_done", 32'(rx_done), 32'h0);
        check_val("midrst_frame_err", 32'(frame_err), 32'h0);
        check_val("midrst_busy", 32'(busy), 32'h0);
      end
    join
    idle(20);
    check_val("midrst_nothing_emitted", 32'(done_count - d0), 32'd0);
    check_val("midrst_no_err", 32'(err_count - e0), 32'd0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, BIT_T);
    idle(4);
    check_val("midrst_next_done", 32'(done_count - d0), 32'd1);
    check_val("midrst_next_data", 32'(rx_data), 32'h7E);
  endtask

  task automatic test_tolerance();
    int d0, e0;
    idle(10);
    d0 = done_count;
    e0 = err_count;
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b1, FAST_T);
    idle(10);
    check_val("tol_fast_done", 32'(done_count - d0), 32'd1);
    check_val("tol_fast_data", 32'(rx_data), 32'h96);
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b1, SLOW_T);
    idle(10);
    check_val("tol_slow_done", 32'(done_count - d0), 32'd2);
    check_val("tol_slow_data", 32'(rx_data), 32'h96);
    check_val("tol_no_err", 32'(err_count - e0), 32'd0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_midframe();
    test_tolerance();
    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
